// File: rtl/cram_async_ctrl_if.sv
// Signal bundle between fabric logic, the CRAM access controller and the CRAM pin stage.
// slave = controller side; master = fabric/pin-stage side.
interface cram_async_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [22:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [15:0] cram_data_out;
   logic [15:0] cram_data_in;
   logic [5:0]  cram_a;
   logic        cram_clk;
   logic        cram_cre;
   logic        cram_adv_n;
   logic        cram_ce0_n;
   logic        cram_ce1_n;
   logic        cram_oe_n;
   logic        cram_we_n;
   logic        cram_ub_n;
   logic        cram_lb_n;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, cram_data_in,
      output req_ready, rsp_valid, rsp_rdata, cram_data_out, cram_a, cram_clk, cram_cre,
             cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, cram_data_in,
      input  req_ready, rsp_valid, rsp_rdata, cram_data_out, cram_a, cram_clk, cram_cre,
             cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n
   );
endinterface

// File: rtl/cram_async_ctrl.sv
// Single-word asynchronous access sequencer for the multiplexed cellular RAM.
// Every output is registered and computed from the next state plus the latched request.
module cram_async_ctrl #(
   parameter int ADDR_CYCLES     = 2,
   parameter int READ_CYCLES     = 8,
   parameter int WRITE_CYCLES    = 6,
   parameter int RECOVERY_CYCLES = 2
) (
   input logic               clk,
   input logic               reset,
   cram_async_ctrl_if.slave  bus
);
   localparam int MAX_AR = (ADDR_CYCLES > READ_CYCLES) ? ADDR_CYCLES : READ_CYCLES;
   localparam int MAX_WC = (WRITE_CYCLES > RECOVERY_CYCLES) ? WRITE_CYCLES : RECOVERY_CYCLES;
   localparam int MAXP   = (MAX_AR > MAX_WC) ? MAX_AR : MAX_WC;
   localparam int CNT_W  = $clog2(MAXP) + 1;

   typedef enum logic [2:0] {IDLE, ADDR, HOLD, ACCESS, RECOVER} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               write_q;
   logic [22:0]        addr_q;
   logic [15:0]        wdata_q;
   logic [1:0]         be_q;
   logic               accept;
   logic               writeCur;
   logic [22:0]        addrCur;
   logic [15:0]        wdataCur;
   logic [1:0]         beCur;
   logic               ready_q, ready_d;
   logic               rspValid_q, rspValid_d;
   logic [15:0]        rdata_q, rdata_d;
   logic [15:0]        dataOut_q, dataOut_d;
   logic [5:0]         a_q, a_d;
   logic               adv_q, adv_d, ce0_q, ce0_d, ce1_q, ce1_d;
   logic               oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d;

   assign accept   = (state_q == IDLE) && bus.req_valid;
   assign writeCur = accept ? bus.req_write : write_q;
   assign addrCur  = accept ? bus.req_addr  : addr_q;
   assign wdataCur = accept ? bus.req_wdata : wdata_q;
   assign beCur    = accept ? bus.req_be    : be_q;

   // Phase sequencing: the counter reloads with length-1 on entry and the phase ends at zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            state_d = ADDR;
            cnt_d   = CNT_W'(ADDR_CYCLES - 1);
         end
         ADDR: if (cnt_q == '0) begin
            state_d = HOLD;
            cnt_d   = '0;
         end else cnt_d = cnt_q - 1'b1;
         HOLD: begin
            state_d = ACCESS;
            cnt_d   = write_q ? CNT_W'(WRITE_CYCLES - 1) : CNT_W'(READ_CYCLES - 1);
         end
         ACCESS: if (cnt_q == '0) begin
            state_d = RECOVER;
            cnt_d   = CNT_W'(RECOVERY_CYCLES - 1);
         end else cnt_d = cnt_q - 1'b1;
         RECOVER: if (cnt_q == '0) state_d = IDLE;
                  else cnt_d = cnt_q - 1'b1;
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Pin values for the cycle that the next state will occupy.
   always_comb begin
      ready_d    = (state_d == IDLE);
      rspValid_d = 1'b0;
      rdata_d    = rdata_q;
      dataOut_d  = dataOut_q;
      a_d        = a_q;
      adv_d      = 1'b1;
      ce0_d      = 1'b1;
      ce1_d      = 1'b1;
      oe_d       = 1'b1;
      we_d       = 1'b1;
      ub_d       = 1'b1;
      lb_d       = 1'b1;
      case (state_d)
         IDLE: begin
            dataOut_d = '0;
            a_d       = '0;
         end
         ADDR, HOLD, ACCESS: begin
            ce0_d     = addrCur[22];
            ce1_d     = ~addrCur[22];
            a_d       = addrCur[21:16];
            dataOut_d = addrCur[15:0];
            adv_d     = (state_d != ADDR);
            ub_d      = writeCur ? ~beCur[1] : 1'b0;
            lb_d      = writeCur ? ~beCur[0] : 1'b0;
            if (state_d == ACCESS) begin
               if (writeCur) begin
                  we_d      = 1'b0;
                  dataOut_d = wdataCur;
               end else begin
                  oe_d = 1'b0;
               end
            end
         end
         default: ;
      endcase
      if ((state_q == ACCESS) && (state_d == RECOVER)) begin
         rspValid_d = 1'b1;
         if (!write_q) rdata_d = bus.cram_data_in;
      end
   end

   // State, latched request and registered outputs; reset drops every strobe at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         ready_q    <= 1'b1;
         rspValid_q <= 1'b0;
         rdata_q    <= '0;
         dataOut_q  <= '0;
         a_q        <= '0;
         adv_q      <= 1'b1;
         ce0_q      <= 1'b1;
         ce1_q      <= 1'b1;
         oe_q       <= 1'b1;
         we_q       <= 1'b1;
         ub_q       <= 1'b1;
         lb_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         write_q    <= writeCur;
         addr_q     <= addrCur;
         wdata_q    <= wdataCur;
         be_q       <= beCur;
         ready_q    <= ready_d;
         rspValid_q <= rspValid_d;
         rdata_q    <= rdata_d;
         dataOut_q  <= dataOut_d;
         a_q        <= a_d;
         adv_q      <= adv_d;
         ce0_q      <= ce0_d;
         ce1_q      <= ce1_d;
         oe_q       <= oe_d;
         we_q       <= we_d;
         ub_q       <= ub_d;
         lb_q       <= lb_d;
      end
   end

   assign bus.req_ready     = ready_q;
   assign bus.rsp_valid     = rspValid_q;
   assign bus.rsp_rdata     = rdata_q;
   assign bus.cram_data_out = dataOut_q;
   assign bus.cram_a        = a_q;
   assign bus.cram_clk      = 1'b0;
   assign bus.cram_cre      = 1'b0;
   assign bus.cram_adv_n    = adv_q;
   assign bus.cram_ce0_n    = ce0_q;
   assign bus.cram_ce1_n    = ce1_q;
   assign bus.cram_oe_n     = oe_q;
   assign bus.cram_we_n     = we_q;
   assign bus.cram_ub_n     = ub_q;
   assign bus.cram_lb_n     = lb_q;
endmodule

// File: tb/tb_cram_async_ctrl.sv
// Bench for cram_async_ctrl: directed accesses, a response scoreboard drained by a monitor,
// plus a second instance with every phase length set to one.
module tb_cram_async_ctrl;
   logic clk;
   logic reset;
   int   cyc;
   int   vectors;
   int   miscompares;
   logic [15:0] modelData;
   logic [15:0] lastRd;

   typedef struct {
      logic [15:0] rdata;
      int          lat;
   } exp_t;

   exp_t expQ[$];
   int   accQ[$];
   int   accLog[$];

   cram_async_ctrl_if bus ();
   cram_async_ctrl_if bus1 ();

   cram_async_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   cram_async_ctrl #(
      .ADDR_CYCLES     (1),
      .READ_CYCLES     (1),
      .WRITE_CYCLES    (1),
      .RECOVERY_CYCLES (1)
   ) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   assign bus.cram_data_in  = bus.cram_oe_n  ? 16'h0000 : modelData;
   assign bus1.cram_data_in = bus1.cram_oe_n ? 16'h0000 : 16'hC0DE;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter and acceptance log; an acceptance is stamped with the count of its edge.
   initial cyc = 0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!reset && bus.req_valid && bus.req_ready) begin
         accQ.push_back(cyc);
         accLog.push_back(cyc);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors = vectors + 1;
      if (act !== req) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s: got %h, wanted %h", name, act, req);
      end
   endtask

   // Monitor: every response pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.rsp_valid) begin
         if (expQ.size() == 0 || accQ.size() == 0) begin
            checkOutput("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            int   a;
            e = expQ.pop_front();
            a = accQ.pop_front();
            checkOutput("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            checkOutput("rsp_latency", 32'(cyc - a + 1), 32'(e.lat));
         end
      end
   end

   // Waits for an idle controller, presents the request and returns just after the accepting edge.
   task automatic applyStimulus(input logic wr, input logic [22:0] addr, input logic [15:0] wd,
                                input logic [1:0] be);
      int t;
      t = 0;
      @(negedge clk);
      while (!bus.req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      bus.req_be    = be;
      bus.req_valid = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      int oeCount;
      int rspK;
      int readyK;
      int t;
      vectors       = 0;
      miscompares   = 0;
      modelData     = 16'h0000;
      lastRd        = 16'h0000;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus1.req_valid = 1'b0;
      bus1.req_write = 1'b0;
      bus1.req_addr  = '0;
      bus1.req_wdata = '0;
      bus1.req_be    = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_strobes", 32'({bus.cram_adv_n, bus.cram_ce0_n, bus.cram_ce1_n, bus.cram_oe_n,
                                      bus.cram_we_n, bus.cram_ub_n, bus.cram_lb_n}), 32'h7F);
      checkOutput("rst_clk_cre", 32'({bus.cram_clk, bus.cram_cre}), 32'd0);
      checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("rst_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'd0);
      reset = 1'b0;

      // Single read at 0x12ABCD returning 0xBEEF.
      modelData = 16'hBEEF;
      expQ.push_back('{16'hBEEF, 12});
      lastRd = 16'hBEEF;
      applyStimulus(1'b0, 23'h12ABCD, 16'h0000, 2'b11);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         checkOutput($sformatf("rd_ce0_c%0d", k), 32'(bus.cram_ce0_n), (k <= 11) ? 32'd0 : 32'd1);
         checkOutput($sformatf("rd_adv_c%0d", k), 32'(bus.cram_adv_n), (k <= 2) ? 32'd0 : 32'd1);
         checkOutput($sformatf("rd_oe_c%0d", k), 32'(bus.cram_oe_n), (k >= 4 && k <= 11) ? 32'd0 : 32'd1);
         if (k == 1) begin
            checkOutput("rd_a", 32'(bus.cram_a), 32'h12);
            checkOutput("rd_dout", 32'(bus.cram_data_out), 32'hABCD);
            checkOutput("rd_ublb", 32'({bus.cram_ub_n, bus.cram_lb_n, bus.cram_ce1_n}), 32'b001);
         end
         if (k == 14) checkOutput("rd_ready_back", 32'(bus.req_ready), 32'd1);
      end

      // Write with upper byte only to die 1.
      expQ.push_back('{lastRd, 10});
      applyStimulus(1'b1, 23'h400010, 16'h5A5A, 2'b10);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         checkOutput($sformatf("wr_ce1_c%0d", k), 32'(bus.cram_ce1_n), (k <= 9) ? 32'd0 : 32'd1);
         checkOutput($sformatf("wr_we_c%0d", k), 32'(bus.cram_we_n), (k >= 4 && k <= 9) ? 32'd0 : 32'd1);
         if (k == 1) checkOutput("wr_bytes", 32'({bus.cram_ce0_n, bus.cram_ub_n, bus.cram_lb_n}), 32'b101);
         if (k == 4) checkOutput("wr_dout", 32'(bus.cram_data_out), 32'h5A5A);
      end

      // Write with no byte enables still runs but masks both bytes.
      expQ.push_back('{lastRd, 10});
      applyStimulus(1'b1, 23'h000020, 16'h1111, 2'b00);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (k == 5) checkOutput("wr0_bytes", 32'({bus.cram_we_n, bus.cram_ub_n, bus.cram_lb_n}), 32'b011);
      end

      // Back-to-back: valid held across a write followed by a read.
      modelData = 16'h7E57;
      expQ.push_back('{lastRd, 10});
      applyStimulus(1'b1, 23'h000333, 16'hA5A5, 2'b11);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.req_write = 1'b0;
            bus.req_addr  = 23'h000100;
            expQ.push_back('{16'h7E57, 12});
         end
         if (k == 10 || k == 11)
            checkOutput($sformatf("b2b_gap_c%0d", k), 32'({bus.cram_ce0_n, bus.cram_ce1_n}), 32'b11);
         if (k == 11) checkOutput("b2b_notready", 32'(bus.req_ready), 32'd0);
         if (k == 12) checkOutput("b2b_ready", 32'(bus.req_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (accLog.size() >= 2)
         checkOutput("b2b_spacing", 32'(accLog[accLog.size()-1] - accLog[accLog.size()-2]), 32'd12);
      else
         checkOutput("b2b_accepts", 32'(accLog.size()), 32'd2);
      lastRd = 16'h7E57;
      repeat (14) @(negedge clk);

      // Reset in the fifth oe_n-low cycle of a read: access abandoned, no response.
      modelData = 16'hDEAD;
      applyStimulus(1'b0, 23'h055555, 16'h0000, 2'b00);
      oeCount = 0;
      t = 0;
      while (oeCount < 5 && t < 30) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         if (!bus.cram_oe_n) oeCount++;
         t++;
      end
      checkOutput("abort_oe_cycles", 32'(oeCount), 32'd5);
      reset = 1'b1;
      #1;
      checkOutput("abort_strobes", 32'({bus.cram_ce0_n, bus.cram_oe_n, bus.cram_adv_n}), 32'b111);
      checkOutput("abort_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'd0);
      repeat (2) @(negedge clk);
      accQ.delete();
      reset = 1'b0;
      lastRd = 16'h0000;
      repeat (16) @(negedge clk);

      modelData = 16'h1234;
      expQ.push_back('{16'h1234, 12});
      lastRd = 16'h1234;
      applyStimulus(1'b0, 23'h3F0042, 16'h0000, 2'b00);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (14) @(negedge clk);

      // All-ones parameter instance.
      @(negedge clk);
      bus1.req_addr  = 23'h000007;
      bus1.req_valid = 1'b1;
      @(posedge clk);
      rspK   = 0;
      readyK = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus1.req_valid = 1'b0;
         if (rspK == 0 && bus1.rsp_valid) begin
            rspK = k;
            checkOutput("p1_rdata", 32'(bus1.rsp_rdata), 32'hC0DE);
         end
         if (readyK == 0 && bus1.req_ready) readyK = k;
      end
      checkOutput("p1_rsp_cycle", 32'(rspK), 32'd4);
      checkOutput("p1_ready_cycle", 32'(readyK), 32'd5);

      t = 0;
      while (expQ.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
